// File: rtl/cfg_loader.sv
// Configuration chain loader: serialises words LSB-first into a fabric shift chain,
// then strobes cfg_cset and waits (with timeout) for its echo from the chain end.
module cfg_loader #(
  parameter int WORD_W     = 32,
  parameter int CHAIN_LEN  = 4096,
  parameter int SET_CYCLES = 2,
  parameter int TIMEOUT    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] word_data,
  input  logic              word_valid,
  output logic              word_ready,
  output logic              cfg_cen,
  output logic              cfg_shift,
  output logic              cfg_cset,
  input  logic              cfg_cset_ret,
  output logic              busy,
  output logic              done,
  output logic              err
);

  localparam int BL_W = $clog2(CHAIN_LEN + 1);
  localparam int WC_W = $clog2(WORD_W + 1);
  localparam int TO_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam int SC_W = $clog2(SET_CYCLES + 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_SHIFT    = 3'd2,
    S_SET      = 3'd3,
    S_WAIT_RET = 3'd4,
    S_DONE     = 3'd5
  } state_t;

  state_t            state_q, state_d;
  logic [BL_W-1:0]   bits_left_q, bits_left_d;
  logic [WC_W-1:0]   wcnt_q, wcnt_d;
  logic [TO_W-1:0]   tmo_q, tmo_d;
  logic [SC_W-1:0]   set_cnt_q, set_cnt_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              err_q, err_d;
  logic              seen_q, seen_d;
  logic [31:0]       bits_left_ext;

  assign bits_left_ext = 32'(bits_left_q);

  // Next-state and datapath update.
  always_comb begin
    state_d     = state_q;
    bits_left_d = bits_left_q;
    wcnt_d      = wcnt_q;
    tmo_d       = tmo_q;
    set_cnt_d   = set_cnt_q;
    shreg_d     = shreg_q;
    err_d       = err_q;
    seen_d      = seen_q;

    if (cfg_cset_ret && (state_q == S_SET || state_q == S_WAIT_RET)) begin
      seen_d = 1'b1;
    end else begin
      seen_d = seen_d;
    end

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d     = S_LOAD;
          err_d       = 1'b0;
          seen_d      = 1'b0;
          bits_left_d = BL_W'(CHAIN_LEN);
        end else begin
          state_d = S_IDLE;
        end
      end
      S_LOAD: begin
        if (word_valid) begin
          shreg_d = word_data;
          // The final word may be only partly used; its upper bits never leave shreg.
          wcnt_d  = (bits_left_ext < 32'(WORD_W)) ? WC_W'(bits_left_q) : WC_W'(WORD_W);
          state_d = S_SHIFT;
        end else begin
          state_d = S_LOAD;
        end
      end
      S_SHIFT: begin
        shreg_d     = shreg_q >> 1;
        wcnt_d      = wcnt_q - WC_W'(1);
        bits_left_d = bits_left_q - BL_W'(1);
        if (bits_left_q == BL_W'(1)) begin
          state_d   = S_SET;
          set_cnt_d = '0;
        end else if (wcnt_q == WC_W'(1)) begin
          state_d = S_LOAD;
        end else begin
          state_d = S_SHIFT;
        end
      end
      S_SET: begin
        if (set_cnt_q == SC_W'(SET_CYCLES - 1)) begin
          state_d = S_WAIT_RET;
          tmo_d   = '0;
        end else begin
          set_cnt_d = set_cnt_q + SC_W'(1);
        end
      end
      S_WAIT_RET: begin
        if (seen_q || cfg_cset_ret) begin
          state_d = S_DONE;
        end else if (tmo_q == TO_W'(TIMEOUT)) begin
          err_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          tmo_d = tmo_q + TO_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Abort wins over every other transition and leaves err untouched.
    if (abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      err_d   = err_q;
    end else begin
      state_d = state_d;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= S_IDLE;
      bits_left_q <= '0;
      wcnt_q      <= '0;
      tmo_q       <= '0;
      set_cnt_q   <= '0;
      shreg_q     <= '0;
      err_q       <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      bits_left_q <= bits_left_d;
      wcnt_q      <= wcnt_d;
      tmo_q       <= tmo_d;
      set_cnt_q   <= set_cnt_d;
      shreg_q     <= shreg_d;
      err_q       <= err_d;
      seen_q      <= seen_d;
    end
  end

  assign word_ready = (state_q == S_LOAD);
  assign cfg_cen    = (state_q == S_SHIFT);
  assign cfg_shift  = cfg_cen & shreg_q[0];
  assign cfg_cset   = (state_q == S_SET);
  assign busy       = (state_q != S_IDLE);
  assign done       = (state_q == S_DONE);
  assign err        = err_q;

endmodule
